mux_scan_ctrl: RTL
==================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter HOLD, default 1: cycles each sel value is held; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: request to scan data_in, sampled only in IDLE.
REQ-005 SHALL have port data_in, input, 4: word to present to the downstream 4:1 mux.
REQ-006 SHALL have port mux_out, input, 1: looped-back output of the downstream 4:1 mux.
REQ-007 SHALL have port sel, output, 2: registered select driving the mux.
REQ-008 SHALL have port mux_in, output, 4: registered data word driving the mux inputs.
REQ-009 SHALL have port busy, output, 1: high in SCAN and DONE.
REQ-010 SHALL have port bit_valid, output, 1: high in the cycle mux_out is sampled.
REQ-011 SHALL have port captured, output, 4: bits sampled from mux_out, bit i sampled at sel=i.
REQ-012 SHALL have port done, output, 1: one-cycle pulse at scan end.
REQ-013 SHALL have port match, output, 1: captured equals mux_in for the last completed scan.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, DONE; only IDLE accepts start.
REQ-015 SHALL, on a rising edge in IDLE with start=1, load mux_in<=data_in, sel<=0, hold counter<=0, captured<=0, match<=0, and enter SCAN.
REQ-016 SHALL, in IDLE with start=0, hold all outputs unchanged.
REQ-017 SHALL hold each sel value for exactly HOLD cycles in SCAN; hold counter counts 0..HOLD-1.
REQ-018 SHALL drive bit_valid combinationally as (state==SCAN && hold counter==HOLD-1).
REQ-019 SHALL, on the edge ending a bit_valid cycle, write captured[sel]<=mux_out, clear the hold counter, and increment sel.
REQ-020 SHALL, when the bit_valid cycle has sel=3, enter DONE with sel wrapping to 0.
REQ-021 SHALL assert done for exactly one cycle, the DONE cycle, then return to IDLE.
REQ-022 SHALL update match<=(captured==mux_in) on the edge leaving DONE and hold it until the next accepted start.
REQ-023 SHALL keep busy high for exactly 4*HOLD+1 cycles per scan.
REQ-024 SHALL ignore start, and any data_in change, while busy; mux_in SHALL remain stable for the whole scan.
REQ-025 SHALL accept a start asserted in the first IDLE cycle after DONE, giving back-to-back scans with one idle cycle between them.
REQ-026 SHALL treat mux_out as combinational from sel and mux_in; no extra pipeline stage is assumed.

Reset
REQ-027 SHALL, while rst_n=0, force state=IDLE, sel=0, mux_in=0, hold counter=0, captured=0, busy=0, bit_valid=0, done=0, match=0, independent of clk.
REQ-028 SHALL abort any scan in progress when rst_n falls, with no done pulse, and leave match at 0.
REQ-029 SHALL require start after rst_n rises before any scan begins.

Verification
REQ-030 SHALL check, with HOLD=1 and an ideal mux, that start with data_in=4'b1011 gives sel 0,1,2,3 on cycles 1-4 and bit_valid high on cycles 1-4. It SHALL also check captured=4'b1011, done on cycle 5, match=1 from cycle 6, and busy high on cycles 1-5 only.
REQ-031 SHALL check, with HOLD=3 and data_in=4'b0110, that each sel is held 3 cycles, bit_valid is high only on the third cycle of each hold, done is on cycle 13, and match=1.
REQ-032 SHALL check that a mux model with input 2 stuck at 0 and data_in=4'b0100 gives captured=4'b0000 and match=0 after done.
REQ-033 SHALL check that pulsing start with data_in=4'b1111 on cycle 2 of a scan of 4'b0001 leaves mux_in=4'b0001, captured=4'b0001, and exactly one done pulse.
REQ-034 SHALL check that asserting rst_n=0 mid-cycle while sel=2 returns all outputs to 0 before the next clk edge, with no done pulse and state IDLE after release.
REQ-035 SHALL check that start held high continuously gives scans separated by exactly one idle cycle, each producing one done pulse.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 2-bit select across a downstream 4:1 mux, holding each
// select for HOLD cycles. It captures the looped-back mux output into a word and
// compares that word against the data it presented to the mux.
module mux_scan_ctrl #(
  parameter int unsigned HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] data_in,
  input  logic       mux_out,
  output logic [1:0] sel,
  output logic [3:0] mux_in,
  output logic       busy,
  output logic       bit_valid,
  output logic [3:0] captured,
  output logic       done,
  output logic       match
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       mux_in_q, mux_in_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [3:0]       captured_q, captured_d;
  logic             match_q, match_d;
  logic             sample;

  // Last cycle of a select hold: mux_out is settled and gets sampled on this edge
  assign sample = (state_q == SCAN) && (hold_q == HOLD_LAST);

  // State register and datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= 2'd0;
      mux_in_q   <= 4'd0;
      hold_q     <= '0;
      captured_q <= 4'd0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      mux_in_q   <= mux_in_d;
      hold_q     <= hold_d;
      captured_q <= captured_d;
      match_q    <= match_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    mux_in_d   = mux_in_q;
    hold_d     = hold_q;
    captured_d = captured_q;
    match_d    = match_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mux_in_d   = data_in;
          sel_d      = 2'd0;
          hold_d     = '0;
          captured_d = 4'd0;
          match_d    = 1'b0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (sample) begin
          captured_d[sel_q] = mux_out;
          hold_d            = '0;
          sel_d             = sel_q + 2'd1;
          if (sel_q == 2'd3) begin
            state_d = DONE;
          end
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      DONE: begin
        match_d = (captured_q == mux_in_q);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from registered state
  assign sel       = sel_q;
  assign mux_in    = mux_in_q;
  assign captured  = captured_q;
  assign match     = match_q;
  assign busy      = (state_q == SCAN) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign bit_valid = sample;

endmodule
